reg_bank_reader: RTL and testbench

- Read-side counterpart to the team's N-bit gated registers.
- On a start request, snapshots a bank of DEPTH registers presented as one flat bus.
- Streams the snapshot out one word at a time over a valid/ready handshake, so downstream logic (display driver, serial transmitter, debug port) can consume register contents at its own pace.
- Sits between the register bank and any single-word consumer.

---
 rtl/reg_bank_reader.sv | 147 ++++++++++++++
 tb/tb_reg_bank_reader.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_reader.sv
// -----------------------------------------------------------------------------
// reg_bank_reader
//
// Snapshots a bank of DEPTH registers (presented as one flat bus) on a start
// request and streams the snapshot out one word at a time over a valid/ready
// handshake, so a single-word consumer can drain it at its own pace.
//
// Optional feature (compile-time macro REG_READER_PARITY_EN):
//   adds o_parity, the even-parity bit (XOR) of o_output_data, registered
//   together with each word. When the macro is undefined the port is absent.
//
// Parameters:
//   N      width of each register word
//   DEPTH  number of registers in the bank (2..16)
//   IDX_W  width of o_index, 2**IDX_W >= DEPTH
//
// Ports:
//   i_clk          system clock, all state updates on the rising edge
//   i_reset        synchronous active-high reset, overrides everything
//   i_start        read-out request (honoured only in IDLE with i_enable=1)
//   i_enable       block enable; low pauses the block
//   i_reg_bank     flat bank, word k = i_reg_bank[k*N +: N]
//   i_ready        downstream accepts the current word
//   o_output_data  current snapshot word (qualify with o_valid)
//   o_valid        o_output_data holds a word ready for transfer
//   o_index        index of the word on o_output_data
//   o_busy         read-out in progress
//   o_done         one-cycle pulse after the last word is accepted
//   o_parity       (REG_READER_PARITY_EN only) XOR of o_output_data
// -----------------------------------------------------------------------------
module reg_bank_reader #(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_enable,
  input  logic [N*DEPTH-1:0] i_reg_bank,
  input  logic               i_ready,
  output logic [N-1:0]       o_output_data,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_index,
  output logic               o_busy,
  output logic               o_done
`ifdef REG_READER_PARITY_EN
  ,
  output logic               o_parity
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [N-1:0]     r_snap [0:DEPTH-1];
  logic [IDX_W-1:0] r_index;
  logic [N-1:0]     r_data;

  logic             w_capture;
  logic             w_valid;
  logic             w_xfer;
  logic             w_last;
  logic [IDX_W-1:0] w_next_idx;

  assign w_capture  = (r_state == ST_IDLE) && i_start && i_enable;
  assign w_valid    = (r_state == ST_SEND) && i_enable;
  assign w_xfer     = w_valid && i_ready;
  assign w_last     = (r_index == IDX_W'(DEPTH - 1));
  // Only used when not on the last word, so it never exceeds DEPTH-1.
  assign w_next_idx = r_index + IDX_W'(1);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic. DONE always lasts exactly one cycle.
  // NOTE: defaulting w_next_state first keeps this block latch-free even if a
  // branch forgets to assign it.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (w_capture)         w_next_state = ST_SEND;
      ST_SEND: if (w_xfer && w_last)  w_next_state = ST_DONE;
      ST_DONE:                        w_next_state = ST_IDLE;
      default:                        w_next_state = ST_IDLE;
    endcase
  end

  // Output decode from registered state (valid also gated by enable).
  always_comb begin
    o_valid = w_valid;
    o_busy  = (r_state == ST_SEND);
    o_done  = (r_state == ST_DONE);
  end

  // Datapath: snapshot, word index and presented word. r_data holds the last
  // emitted word outside SEND, and the next word is preloaded on a transfer
  // so it appears the cycle after acceptance.
  // NOTE: the snapshot array is reset on purpose: reset must leave no stale
  // register contents visible. Memories normally would not be reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < DEPTH; k++) r_snap[k] <= '0;
      r_index <= '0;
      r_data  <= '0;
    end else if (w_capture) begin
      for (int k = 0; k < DEPTH; k++) r_snap[k] <= i_reg_bank[k*N +: N];
      r_index <= '0;
      r_data  <= i_reg_bank[0 +: N];
    end else if (w_xfer) begin
      if (w_last) begin
        r_index <= '0;
      end else begin
        r_index <= w_next_idx;
        r_data  <= r_snap[w_next_idx];
      end
    end
  end

  assign o_output_data = r_data;
  assign o_index       = r_index;

`ifdef REG_READER_PARITY_EN
  logic r_parity;

  // Parity tracks r_data exactly, loaded on the same events.
  always_ff @(posedge i_clk) begin
    if (i_reset)                  r_parity <= 1'b0;
    else if (w_capture)           r_parity <= ^i_reg_bank[0 +: N];
    else if (w_xfer && !w_last)   r_parity <= ^r_snap[w_next_idx];
  end

  assign o_parity = r_parity;
`endif

endmodule

// File: tb/tb_reg_bank_reader.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_reader
//
// Self-checking bench for reg_bank_reader (N=4, DEPTH=4, IDX_W=2). Directed
// scenarios use hand-derived constants; the randomized scenario compares
// against a queue-based reference model of the read-out behaviour.
// Define REG_READER_PARITY_EN for both bench and RTL to exercise parity.
// -----------------------------------------------------------------------------
module tb_reg_bank_reader;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int IDX_W = 2;

  logic               clk;
  logic               r_reset;
  logic               r_start;
  logic               r_enable;
  logic [N*DEPTH-1:0] r_bank;
  logic               r_ready;
  logic [N-1:0]       o_output_data;
  logic               o_valid;
  logic [IDX_W-1:0]   o_index;
  logic               o_busy;
  logic               o_done;
`ifdef REG_READER_PARITY_EN
  logic               o_parity;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  reg_bank_reader #(.N(N), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .i_clk         (clk),
    .i_reset       (r_reset),
    .i_start       (r_start),
    .i_enable      (r_enable),
    .i_reg_bank    (r_bank),
    .i_ready       (r_ready),
    .o_output_data (o_output_data),
    .o_valid       (o_valid),
    .o_index       (o_index),
    .o_busy        (o_busy),
    .o_done        (o_done)
`ifdef REG_READER_PARITY_EN
    ,
    .o_parity      (o_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are changed and outputs are
  // sampled 1-2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    r_reset  = 1'b1;
    r_start  = 1'b0;
    r_enable = 1'b0;
    r_ready  = 1'b0;
    tick();
    tick();
    r_reset  = 1'b0;
  endtask

  // Launch a read-out of bank b with enable and ready high.
  task automatic launch(input logic [N*DEPTH-1:0] b);
    r_bank   = b;
    r_enable = 1'b1;
    r_ready  = 1'b1;
    r_start  = 1'b1;
    tick();
    r_start  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({o_valid, o_busy, o_done, o_index, o_output_data} !== '0) begin
      $display("FAIL reset_state: got v=%b b=%b d=%b i=%0d data=%h, want all 0",
               o_valid, o_busy, o_done, o_index, o_output_data);
    end else n_pass++;
  endtask

  task automatic test_basic();
    logic [N-1:0] exp_w [DEPTH];
    exp_w = '{4'h3, 4'hC, 4'h5, 4'hA};
    do_reset();
    launch(16'hA5C3);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_checks++;
      if (o_valid !== 1'b1 || o_busy !== 1'b1 || o_output_data !== exp_w[i] ||
          o_index !== IDX_W'(i)) begin
        $display("FAIL basic_word%0d: got v=%b b=%b d=%h i=%0d, want v=1 b=1 d=%h i=%0d",
                 i, o_valid, o_busy, o_output_data, o_index, exp_w[i], i);
      end else n_pass++;
      tick();
    end
    #1;
    n_checks++;
    if (o_done !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_index !== '0 ||
        o_output_data !== 4'hA) begin
      $display("FAIL basic_done: got dn=%b v=%b b=%b i=%0d d=%h, want dn=1 v=0 b=0 i=0 d=a",
               o_done, o_valid, o_busy, o_index, o_output_data);
    end else n_pass++;
    tick();
    #1;
    n_checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_valid !== 1'b0 || o_output_data !== 4'hA) begin
      $display("FAIL basic_idle: got dn=%b b=%b v=%b d=%h, want dn=0 b=0 v=0 d=a",
               o_done, o_busy, o_valid, o_output_data);
    end else n_pass++;
  endtask

  task automatic test_backpressure();
    logic         rdy_seq [7];
    logic [N-1:0] d_seq   [7];
    int           i_seq   [7];
    rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    d_seq   = '{4'h3, 4'hC, 4'hC, 4'hC, 4'hC, 4'h5, 4'hA};
    i_seq   = '{0, 1, 1, 1, 1, 2, 3};
    do_reset();
    launch(16'hA5C3);
    for (int i = 0; i < 7; i++) begin
      r_ready = rdy_seq[i];
      #1;
      n_checks++;
      if (o_valid !== 1'b1 || o_output_data !== d_seq[i] || o_index !== IDX_W'(i_seq[i])) begin
        $display("FAIL bp_step%0d: got v=%b d=%h i=%0d, want v=1 d=%h i=%0d",
                 i, o_valid, o_output_data, o_index, d_seq[i], i_seq[i]);
      end else n_pass++;
      tick();
    end
    #1;
    n_checks++;
    if (o_done !== 1'b1 || o_valid !== 1'b0) begin
      $display("FAIL bp_done: got dn=%b v=%b, want dn=1 v=0", o_done, o_valid);
    end else n_pass++;
  endtask

  task automatic test_snapshot();
    logic [N-1:0] exp_w [DEPTH];
    exp_w = '{4'h3, 4'hC, 4'h5, 4'hA};
    do_reset();
    launch(16'hA5C3);
    r_bank = 16'h0000;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_checks++;
      if (o_valid !== 1'b1 || o_output_data !== exp_w[i]) begin
        $display("FAIL snap_word%0d: got v=%b d=%h, want v=1 d=%h",
                 i, o_valid, o_output_data, exp_w[i]);
      end else n_pass++;
      tick();
    end
  endtask

  task automatic test_enable_pause();
    logic         en_seq [6];
    logic         st_seq [6];
    logic         v_seq  [6];
    logic [N-1:0] d_seq  [6];
    int           i_seq  [6];
    en_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    st_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    v_seq  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    d_seq  = '{4'h3, 4'hC, 4'h5, 4'h5, 4'h5, 4'hA};
    i_seq  = '{0, 1, 2, 2, 2, 3};
    do_reset();
    launch(16'hA5C3);
    for (int i = 0; i < 6; i++) begin
      r_enable = en_seq[i];
      r_start  = st_seq[i];
      #1;
      n_checks++;
      if (o_valid !== v_seq[i] || o_busy !== 1'b1 || o_output_data !== d_seq[i] ||
          o_index !== IDX_W'(i_seq[i])) begin
        $display("FAIL pause_step%0d: got v=%b b=%b d=%h i=%0d, want v=%b b=1 d=%h i=%0d",
                 i, o_valid, o_busy, o_output_data, o_index, v_seq[i], d_seq[i], i_seq[i]);
      end else n_pass++;
      tick();
    end
    r_start = 1'b0;
    #1;
    n_checks++;
    if (o_done !== 1'b1 || o_valid !== 1'b0) begin
      $display("FAIL pause_done: got dn=%b v=%b, want dn=1 v=0", o_done, o_valid);
    end else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] exp_w [DEPTH];
    exp_w = '{4'h4, 4'h3, 4'h2, 4'h1};
    do_reset();
    launch(16'hA5C3);
    tick();              // word 0 accepted, now at index 1
    r_reset = 1'b1;
    tick();
    r_reset = 1'b0;
    r_ready = 1'b1;
    #1;
    n_checks++;
    if ({o_valid, o_busy, o_done, o_index, o_output_data} !== '0) begin
      $display("FAIL midreset_state: got v=%b b=%b dn=%b i=%0d d=%h, want all 0",
               o_valid, o_busy, o_done, o_index, o_output_data);
    end else n_pass++;
    launch(16'h1234);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_checks++;
      if (o_valid !== 1'b1 || o_output_data !== exp_w[i] || o_index !== IDX_W'(i)) begin
        $display("FAIL midreset_word%0d: got v=%b d=%h i=%0d, want v=1 d=%h i=%0d",
                 i, o_valid, o_output_data, o_index, exp_w[i], i);
      end else n_pass++;
      tick();
    end
  endtask

`ifdef REG_READER_PARITY_EN
  task automatic test_parity();
    logic [N-1:0] exp_w [DEPTH];
    logic         exp_p [DEPTH];
    exp_w = '{4'h0, 4'h1, 4'h3, 4'h7};
    exp_p = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    launch(16'h7310);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_checks++;
      if (o_valid !== 1'b1 || o_output_data !== exp_w[i] || o_parity !== exp_p[i]) begin
        $display("FAIL parity_word%0d: got v=%b d=%h p=%b, want v=1 d=%h p=%b",
                 i, o_valid, o_output_data, o_parity, exp_w[i], exp_p[i]);
      end else n_pass++;
      tick();
    end
  endtask
`endif

  // Randomized traffic against a queue model: a read-out is a queue of the
  // captured words; each accepted transfer pops the head.
  task automatic test_random();
    int           ph;      // 0 idle, 1 sending, 2 done pulse
    logic [N-1:0] q [$];
    int           idx;
    logic [N-1:0] last;
    logic         e_valid;
    do_reset();
    ph = 0; idx = 0; last = '0;
    for (int c = 0; c < 400; c++) begin
      r_start  = ($urandom_range(0, 3) == 0);
      r_enable = ($urandom_range(0, 4) != 0);
      r_ready  = ($urandom_range(0, 2) != 0);
      r_bank   = N*DEPTH'($urandom);
      #1;
      e_valid = (ph == 1) && r_enable;
      n_checks++;
      if (o_valid !== e_valid || o_busy !== (ph == 1) || o_done !== (ph == 2) ||
          o_index !== IDX_W'(idx) || o_output_data !== last
`ifdef REG_READER_PARITY_EN
          || o_parity !== ^last
`endif
         ) begin
        $display("FAIL rand_cycle%0d: got v=%b b=%b dn=%b i=%0d d=%h, want v=%b b=%b dn=%b i=%0d d=%h",
                 c, o_valid, o_busy, o_done, o_index, o_output_data,
                 e_valid, ph == 1, ph == 2, idx, last);
      end else n_pass++;
      tick();
      case (ph)
        0: if (r_start && r_enable) begin
             q.delete();
             for (int k = 0; k < DEPTH; k++) q.push_back(r_bank[k*N +: N]);
             idx  = 0;
             last = q[0];
             ph   = 1;
           end
        1: if (r_enable && r_ready) begin
             void'(q.pop_front());
             if (q.size() == 0) begin
               ph  = 2;
               idx = 0;
             end else begin
               idx++;
               last = q[0];
             end
           end
        default: ph = 0;
      endcase
    end
  endtask

  initial begin
    r_reset  = 1'b1;
    r_start  = 1'b0;
    r_enable = 1'b0;
    r_ready  = 1'b0;
    r_bank   = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_enable_pause();
    test_reset_mid();
`ifdef REG_READER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
